mlaccel_memarb: RTL

MLACCEL_MEMARB -- requirements
Module: mlaccel_memarb

---
 rtl/mlaccel_memarb.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mlaccel_memarb.sv
// mlaccel_memarb: single-port memory arbiter for the ML accelerator.
// Three requesters share one 64-bit memory port, with at most one access
// issued per cycle:
//   compute (cmem_*) - highest priority, drives the port directly
//   qmem    (qmem_*) - QPI-side 16-bit reads/writes
//   smem    (smem_*) - sequencer 32-bit fetches (read only)
// When compute is idle or stalled, qmem and smem share the port round-robin.
// The last-grant register resets to smem, so qmem wins the first tie.
// Reads return data one cycle after the grant. A requester with a read in
// flight is not eligible again until that data has been returned.
//
// Optional feature, macro MLACCEL_MEMARB_STARVE_EN:
//   defined   - a starvation counter tracks how long qmem/smem requests have
//               been blocked by compute. After STARVE_LIMIT blocked cycles,
//               cmem_stall is raised for one cycle and the waiting requester
//               is served in that cycle.
//   undefined - cmem_stall is tied low and no counter is built, so compute
//               can starve qmem/smem indefinitely.

module mlaccel_memarb #(
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        cmem_ren,
  input  logic [7:0]  cmem_wen,
  input  logic [15:0] cmem_addr,
  input  logic [63:0] cmem_wdata,
  output logic [63:0] cmem_rdata,
  output logic        cmem_stall,

  input  logic        qmem_valid,
  input  logic [1:0]  qmem_wen,
  input  logic [15:0] qmem_addr,
  input  logic [15:0] qmem_wdata,
  output logic        qmem_gnt,
  output logic        qmem_rvalid,
  output logic [15:0] qmem_rdata,

  input  logic        smem_valid,
  input  logic [15:0] smem_addr,
  output logic        smem_ready,
  output logic [31:0] smem_data,

  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wen,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic {
    LG_QMEM = 1'b0,
    LG_SMEM = 1'b1
  } last_grant_e;

  last_grant_e last_q, last_d;
  logic        q_pend_q, q_pend_d;
  logic        s_pend_q, s_pend_d;

  logic        comp_req;
  logic        comp_win;
  logic        q_elig;
  logic        s_elig;
  logic        gnt_q;
  logic        gnt_s;

  // Limits outside 1..255 are not a legal configuration; nothing is built for them.
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_starve_limit
  end

  assign comp_req = cmem_ren | (|cmem_wen);
  assign comp_win = comp_req & ~cmem_stall;
  assign q_elig   = qmem_valid & ~q_pend_q;
  assign s_elig   = smem_valid & ~s_pend_q;

  // Pick the qmem/smem winner; ties go to the side not served most recently.
  always_comb begin
    gnt_q = 1'b0;
    gnt_s = 1'b0;
    if (!comp_win) begin
      if (q_elig && s_elig) begin
        if (last_q == LG_SMEM) begin
          gnt_q = 1'b1;
        end else begin
          gnt_s = 1'b1;
        end
      end else begin
        gnt_q = q_elig;
        gnt_s = s_elig;
      end
    end
  end

  // Memory port mux; with nothing granted the port idles on the compute address.
  always_comb begin
    mem_addr  = cmem_addr;
    mem_wen   = 8'h00;
    mem_wdata = cmem_wdata;
    if (comp_win) begin
      mem_wen = cmem_wen;
    end else if (gnt_q) begin
      mem_addr  = qmem_addr;
      mem_wen   = {6'b0, qmem_wen};
      mem_wdata = {4{qmem_wdata}};
    end else if (gnt_s) begin
      mem_addr = smem_addr;
    end
  end

  // Next-state for the outstanding-read flags and the last-grant record.
  always_comb begin
    q_pend_d = gnt_q & (qmem_wen == 2'b00);
    s_pend_d = gnt_s;
    last_d   = last_q;
    if (gnt_q) begin
      last_d = LG_QMEM;
    end else if (gnt_s) begin
      last_d = LG_SMEM;
    end
  end

  // Arbitration state; reset drops any read in flight so no response follows.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_pend_q <= 1'b0;
      s_pend_q <= 1'b0;
      last_q   <= LG_SMEM;
    end else begin
      q_pend_q <= q_pend_d;
      s_pend_q <= s_pend_d;
      last_q   <= last_d;
    end
  end

  // Pending flags double as the response strobes; data comes straight from memory.
  assign qmem_gnt    = gnt_q;
  assign qmem_rvalid = q_pend_q;
  assign qmem_rdata  = mem_rdata[15:0];
  assign smem_ready  = s_pend_q;
  assign smem_data   = mem_rdata[31:0];
  assign cmem_rdata  = mem_rdata;

`ifdef MLACCEL_MEMARB_STARVE_EN
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  logic [7:0] starve_q, starve_d;
  logic       stall_q, stall_d;

  // Count consecutive cycles in which compute holds off a waiting qmem/smem
  // request. The cycle after a read grant also counts when the requester
  // already holds its next request, which keeps the stall period at exactly
  // STARVE_LIMIT+1 cycles under continuous pressure.
  always_comb begin
    starve_d = 8'd0;
    stall_d  = 1'b0;
    if (!stall_q && comp_req && (qmem_valid || smem_valid)) begin
      if ((starve_q + 8'd1) == STARVE_LIM) begin
        stall_d = 1'b1;
      end else begin
        starve_d = starve_q + 8'd1;
      end
    end
  end

  // Starvation counter and the registered one-cycle compute stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= 8'd0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign cmem_stall = stall_q;
`else
  assign cmem_stall = 1'b0;
`endif

endmodule
